// File: rtl/hazard_sequencer_pkg.sv
// Shared pipeline-control definitions: FSM encoding, hazard priority and default sizing.
package hazard_sequencer_pkg;

  localparam int DEF_MEM_TIMEOUT = 255;
  localparam int DEF_CNT_W       = 16;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_FLUSH      = 2'd2,
    ST_MEM_WAIT   = 2'd3
  } state_e;

  // Encoded so that a numerically larger hazard always wins.
  typedef enum logic [1:0] {
    HZ_NONE      = 2'd0,
    HZ_LOAD_USE  = 2'd1,
    HZ_REDIRECT  = 2'd2,
    HZ_MEM_STALL = 2'd3
  } hazard_e;

  function automatic hazard_e resolve_hazard(input logic ms, input logic rd, input logic lu);
    if (ms)      return HZ_MEM_STALL;
    else if (rd) return HZ_REDIRECT;
    else if (lu) return HZ_LOAD_USE;
    else         return HZ_NONE;
  endfunction

endpackage

// File: rtl/hazard_sequencer_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != '1))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard control: stall/flush/freeze enables, hazard FSM, event counters, memory timeout.
// state | meaning: RUN no hazard, LOAD_STALL load-use bubble, FLUSH redirect, MEM_WAIT memory freeze
module hazard_sequencer
  import hazard_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic [4:0]       de_rd_i,
  input  logic             de_mem_read_i,
  input  logic             de_reg_write_i,
  input  logic             ex_branch_taken_i,
  input  logic             ex_jump_i,
  input  logic             em_mem_access_i,
  input  logic             dmem_ready_i,
  output logic             pc_en_o,
  output logic             fd_en_o,
  output logic             de_en_o,
  output logic             em_en_o,
  output logic             fd_flush_o,
  output logic             de_flush_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             mem_timeout_o
);

  localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic              cond_ms, cond_rd, cond_lu;
  hazard_e           hazard;
  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_timeout_q, mem_timeout_d;
  logic              stall_inc, flush_inc;

  assign cond_ms = em_mem_access_i & ~dmem_ready_i;
  assign cond_rd = ex_branch_taken_i | ex_jump_i;
  assign cond_lu = de_mem_read_i & de_reg_write_i & (de_rd_i != 5'd0) &
                   ((id_uses_rs1_i & (id_rs1_i == de_rd_i)) |
                    (id_uses_rs2_i & (id_rs2_i == de_rd_i)));

  assign hazard = resolve_hazard(cond_ms, cond_rd, cond_lu);

  always_comb begin
    pc_en_o    = 1'b1;
    fd_en_o    = 1'b1;
    de_en_o    = 1'b1;
    em_en_o    = 1'b1;
    fd_flush_o = 1'b0;
    de_flush_o = 1'b0;
    state_d    = ST_RUN;
    case (hazard)
      HZ_MEM_STALL: begin
        pc_en_o = 1'b0;
        fd_en_o = 1'b0;
        de_en_o = 1'b0;
        em_en_o = 1'b0;
        state_d = ST_MEM_WAIT;
      end
      HZ_REDIRECT: begin
        fd_flush_o = 1'b1;
        de_flush_o = 1'b1;
        state_d    = ST_FLUSH;
      end
      HZ_LOAD_USE: begin
        pc_en_o    = 1'b0;
        fd_en_o    = 1'b0;
        de_flush_o = 1'b1;
        state_d    = ST_LOAD_STALL;
      end
      default: ;
    endcase
    // Reset holds the pipeline frozen with bubbles regardless of conditions.
    if (rst_i) begin
      pc_en_o    = 1'b0;
      fd_en_o    = 1'b0;
      de_en_o    = 1'b0;
      em_en_o    = 1'b0;
      fd_flush_o = 1'b1;
      de_flush_o = 1'b1;
    end
  end

  assign mem_timeout_d = mem_timeout_q | (cond_ms & (wait_cnt >= WAIT_LAST));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_RUN;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign stall_inc = (hazard == HZ_MEM_STALL) | (hazard == HZ_LOAD_USE);
  assign flush_inc = (hazard == HZ_REDIRECT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (1'b0),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (1'b0),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt_o)
  );

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (~cond_ms),
    .inc_i (cond_ms),
    .cnt_o (wait_cnt)
  );

  assign state_o       = state_q;
  assign mem_timeout_o = mem_timeout_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed hazard scenarios then randomized traffic vs. a behavioural model.
module tb_hazard_sequencer;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [4:0]       id_rs1_i, id_rs2_i, de_rd_i;
  logic             id_uses_rs1_i, id_uses_rs2_i;
  logic             de_mem_read_i, de_reg_write_i;
  logic             ex_branch_taken_i, ex_jump_i;
  logic             em_mem_access_i, dmem_ready_i;
  logic             pc_en_o, fd_en_o, de_en_o, em_en_o, fd_flush_o, de_flush_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
  logic             mem_timeout_o;

  hazard_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .id_rs1_i          (id_rs1_i),
    .id_rs2_i          (id_rs2_i),
    .id_uses_rs1_i     (id_uses_rs1_i),
    .id_uses_rs2_i     (id_uses_rs2_i),
    .de_rd_i           (de_rd_i),
    .de_mem_read_i     (de_mem_read_i),
    .de_reg_write_i    (de_reg_write_i),
    .ex_branch_taken_i (ex_branch_taken_i),
    .ex_jump_i         (ex_jump_i),
    .em_mem_access_i   (em_mem_access_i),
    .dmem_ready_i      (dmem_ready_i),
    .pc_en_o           (pc_en_o),
    .fd_en_o           (fd_en_o),
    .de_en_o           (de_en_o),
    .em_en_o           (em_en_o),
    .fd_flush_o        (fd_flush_o),
    .de_flush_o        (de_flush_o),
    .state_o           (state_o),
    .stall_cnt_o       (stall_cnt_o),
    .flush_cnt_o       (flush_cnt_o),
    .mem_timeout_o     (mem_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pipeline mode, event counts, consecutive memory-wait run, sticky timeout.
  int m_state, m_stall, m_flush, m_wait;
  bit m_to;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void conds(output bit ms, output bit rd, output bit lu);
    ms = em_mem_access_i && !dmem_ready_i;
    rd = ex_branch_taken_i || ex_jump_i;
    lu = de_mem_read_i && de_reg_write_i && (de_rd_i != 0) &&
         ((id_uses_rs1_i && id_rs1_i == de_rd_i) || (id_uses_rs2_i && id_rs2_i == de_rd_i));
  endfunction

  task automatic model_reset();
    m_state = 0; m_stall = 0; m_flush = 0; m_wait = 0; m_to = 0;
  endtask

  task automatic model_update();
    bit ms, rd, lu;
    if (rst_i) begin
      model_reset();
    end else begin
      conds(ms, rd, lu);
      m_state = ms ? 3 : rd ? 2 : lu ? 1 : 0;
      if ((ms || (lu && !rd)) && m_stall < CNT_MAX) m_stall++;
      if (!ms && rd && m_flush < CNT_MAX) m_flush++;
      m_wait = ms ? m_wait + 1 : 0;
      if (m_wait >= MEM_TIMEOUT) m_to = 1;
    end
  endtask

  task automatic check_all();
    bit ms, rd, lu;
    int exp_ctrl;
    conds(ms, rd, lu);
    // {pc_en, fd_en, de_en, em_en, fd_flush, de_flush}
    if (rst_i)   exp_ctrl = 'b000011;
    else if (ms) exp_ctrl = 'b000000;
    else if (rd) exp_ctrl = 'b111111;
    else if (lu) exp_ctrl = 'b001101;
    else         exp_ctrl = 'b111100;
    check_eq("ctrl", {pc_en_o, fd_en_o, de_en_o, em_en_o, fd_flush_o, de_flush_o}, exp_ctrl);
    check_eq("state", state_o, m_state);
    check_eq("stall_cnt", stall_cnt_o, m_stall);
    check_eq("flush_cnt", flush_cnt_o, m_flush);
    check_eq("mem_timeout", mem_timeout_o, m_to);
  endtask

  task automatic cycle();
    @(negedge clk_i);
    check_all();
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input bit u1, input bit u2,
                        input logic [4:0] drd, input bit mr, input bit rw, input bit br,
                        input bit jp, input bit ma, input bit rdy);
    id_rs1_i = rs1; id_rs2_i = rs2; id_uses_rs1_i = u1; id_uses_rs2_i = u2;
    de_rd_i = drd; de_mem_read_i = mr; de_reg_write_i = rw;
    ex_branch_taken_i = br; ex_jump_i = jp; em_mem_access_i = ma; dmem_ready_i = rdy;
  endtask

  int burst;

  initial begin
    rst_i = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    model_reset();
    cycle();
    cycle();
    rst_i = 1'b0;

    // Load-use on rs2 = x5
    set_in(0, 5, 0, 1, 5, 1, 1, 0, 0, 0, 1);
    cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check_eq("lu_state", state_o, 1);
    check_eq("lu_stall", stall_cnt_o, 1);
    cycle();

    // Load to x0 never stalls
    set_in(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 1);
    cycle();

    // Branch beats a simultaneous load-use
    set_in(3, 0, 1, 0, 3, 1, 1, 1, 0, 0, 1);
    cycle();
    check_eq("br_state", state_o, 2);
    check_eq("br_flush", flush_cnt_o, 1);
    check_eq("br_stall", stall_cnt_o, 1);

    // Memory stall with jump held: freeze 3 cycles, then redirect applies
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    repeat (3) cycle();
    check_eq("ms_stall", stall_cnt_o, 4);
    check_eq("ms_state", state_o, 3);
    dmem_ready_i = 1'b1;
    cycle();
    check_eq("ms_after_state", state_o, 2);

    // Timeout after 4 consecutive wait cycles, sticky afterwards
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) cycle();
    check_eq("to_early", mem_timeout_o, 0);
    cycle();
    check_eq("to_set", mem_timeout_o, 1);
    repeat (2) cycle();
    dmem_ready_i = 1'b1;
    repeat (3) cycle();
    check_eq("to_sticky", mem_timeout_o, 1);

    // Async reset in the middle of a memory wait
    dmem_ready_i = 1'b0;
    repeat (2) cycle();
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    model_reset();
    check_all();
    check_eq("rst_state", state_o, 0);
    check_eq("rst_timeout", mem_timeout_o, 0);
    @(posedge clk_i);
    model_update();
    #1 rst_i = 1'b0;
    cycle();

    // Randomized traffic with memory-wait bursts and occasional resets
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      id_rs1_i          = 5'($urandom_range(0, 3));
      id_rs2_i          = 5'($urandom_range(0, 3));
      de_rd_i           = 5'($urandom_range(0, 3));
      id_uses_rs1_i     = ($urandom_range(0, 1) == 1);
      id_uses_rs2_i     = ($urandom_range(0, 1) == 1);
      de_mem_read_i     = ($urandom_range(0, 1) == 1);
      de_reg_write_i    = ($urandom_range(0, 3) != 0);
      ex_branch_taken_i = ($urandom_range(0, 7) == 0);
      ex_jump_i         = ($urandom_range(0, 11) == 0);
      if (burst > 0) begin
        em_mem_access_i = 1'b1;
        dmem_ready_i    = 1'b0;
        burst--;
      end else begin
        em_mem_access_i = ($urandom_range(0, 3) == 0);
        dmem_ready_i    = ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 19) == 0) burst = $urandom_range(1, 7);
      end
      rst_i = ($urandom_range(0, 149) == 0);
      if (rst_i) model_reset();
      cycle();
    end
    rst_i = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
